kbd_count_ctrl: RTL

KBD_COUNT_CTRL -- requirements
Module: kbd_count_ctrl

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/kbd_timeout_timer.sv | 30 +++
 rtl/kbd_count_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared FSM state type and PS/2 scan-code constants for the key-press counter.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_t;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;

    // Keyboard error/overrun bytes are dropped wherever they appear.
    function automatic logic is_err_code(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/kbd_timeout_timer.sv
// Idle-cycle timer that abandons a half-received E0/F0 prefix.
module kbd_timeout_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic clrn,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_reg;

    // Fires during the TIMEOUT_CYC-th consecutive idle cycle spent in a prefix state.
    assign expired = run && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_reg <= '0;
        end else if (!run || restart) begin
            cnt_reg <= '0;
        end else if (!expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/kbd_count_ctrl.sv
// PS/2 scan-code decoder that tracks the held key and counts distinct key presses.
module kbd_count_ctrl
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       code_valid,
    input  logic [7:0] code_data,
    input  logic       cnt_clr,
    output logic [7:0] mycount,
    output logic [7:0] key_code,
    output logic       ext_flag,
    output logic       key_down,
    output logic       press_pulse
);

    kbd_state_t state_reg;
    kbd_state_t state_next;
    logic       make_ev;
    logic       brk_ev;
    logic       ev_ext;
    logic       key_match;
    logic       expired;

    kbd_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .clrn   (clrn),
        .run    (state_reg != IDLE),
        .restart(code_valid),
        .expired(expired)
    );

    // A received byte always takes priority over a coincident timeout.
    always_comb begin
        state_next = state_reg;
        make_ev    = 1'b0;
        brk_ev     = 1'b0;
        ev_ext     = 1'b0;
        if (code_valid) begin
            if (is_err_code(code_data)) begin
                state_next = IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (code_data == SC_EXT)      state_next = EXT;
                        else if (code_data == SC_BRK) state_next = BRK;
                        else                          make_ev = 1'b1;
                    end
                    EXT: begin
                        if (code_data == SC_BRK)      state_next = EXT_BRK;
                        else if (code_data == SC_EXT) state_next = EXT;
                        else begin
                            make_ev    = 1'b1;
                            ev_ext     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    BRK: begin
                        brk_ev     = 1'b1;
                        state_next = IDLE;
                    end
                    EXT_BRK: begin
                        brk_ev     = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end else if (expired) begin
            state_next = IDLE;
        end
    end

    assign key_match = (key_code == code_data) && (ext_flag == ev_ext);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg   <= IDLE;
            mycount     <= '0;
            key_code    <= '0;
            ext_flag    <= 1'b0;
            key_down    <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            state_reg   <= state_next;
            press_pulse <= 1'b0;
            if (cnt_clr) begin
                mycount <= '0;
            end
            // A make of the already-held key is typematic auto-repeat.
            if (make_ev && !(key_down && key_match)) begin
                mycount     <= cnt_clr ? 8'd0 : mycount + 8'd1;
                key_code    <= code_data;
                ext_flag    <= ev_ext;
                key_down    <= 1'b1;
                press_pulse <= 1'b1;
            end
            if (brk_ev && key_match) begin
                key_down <= 1'b0;
            end
        end
    end

endmodule
